// File: rtl/program_counter_if.sv
// Bus between the timer control FSM and the program counter: reset value,
// load value, load/increment enables, and the current step index.
interface program_counter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ResetVal;
  logic [WIDTH-1:0] LoadVal;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] PCoutput;

  // Controller side: drives values and enables, observes the step index.
  modport master (
    output ResetVal,
    output LoadVal,
    output load,
    output inc,
    input  PCoutput
  );

  // Counter side: consumes values and enables, drives the step index.
  modport slave (
    input  ResetVal,
    input  LoadVal,
    input  load,
    input  inc,
    output PCoutput
  );
endinterface

// File: rtl/program_counter.sv
// Program/step counter for the two-mode timer datapath.
// Asynchronous active-high reset to a runtime value, then per clock:
// load has priority over increment, otherwise the value holds.
// Increments wrap modulo 2^WIDTH.
module program_counter #(
  parameter int WIDTH    = 8,
  parameter int INC_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  bus
);

  // Increment amount truncated to the counter width.
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state selection: load beats increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = bus.LoadVal;
    end else if (bus.inc) begin
      count_d = count_q + STEP;
    end
  end

  // Counter register; reset captures ResetVal immediately and keeps
  // re-capturing it on every clock edge while reset stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= bus.ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  // While reset is held the output follows ResetVal directly, so a change
  // on ResetVal shows up without waiting for a clock. After release the
  // register value (last ResetVal seen at the final edge or the reset
  // assertion) is presented; ResetVal should be stable across the last
  // clock period before release. load/inc/LoadVal never reach the output
  // combinationally.
  assign bus.PCoutput = reset ? bus.ResetVal : count_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter: async reset, load, increment,
// priority, wrap-around, multi-cycle enables and between-edge pulses.
`timescale 1ns/1ps
module tb_program_counter;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  program_counter_if #(.WIDTH(WIDTH)) bus ();

  program_counter #(
    .WIDTH    (WIDTH),
    .INC_STEP (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 100 ns period, rising edges at 50, 150, 250 ns ...
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic goto(input longint t);
    #(t - $time);
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] exp);
    checks++;
    assert (bus.PCoutput === exp) else begin
      errors++;
      $error("FAIL %s: PCoutput=%0d expected=%0d at %0t", tag, bus.PCoutput, exp, $time);
    end
    $display("check %-14s t=%0t PCoutput=%0d expected=%0d", tag, $time, bus.PCoutput, exp);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    bus.ResetVal = 8'd77;
    bus.LoadVal  = 8'd0;
    bus.load     = 1'b0;
    bus.inc      = 1'b0;

    // Async reset before any clock edge
    goto(20);   reset = 1'b1;
    goto(21);   chk("rst_async", 8'd77);
    goto(40);   reset = 1'b0;
    goto(45);   chk("rst_release", 8'd77);

    // Load 22, no combinational path before the edge
    goto(70);   bus.LoadVal = 8'd22; bus.load = 1'b1;
    goto(100);  chk("load_pre_edge", 8'd77);
    goto(160);  chk("load_22", 8'd22);
    goto(170);  bus.load = 1'b0;
    goto(260);  chk("load_hold", 8'd22);

    // Increment for three edges
    goto(270);  bus.inc = 1'b1;
    goto(360);  chk("inc_23", 8'd23);
    goto(460);  chk("inc_24", 8'd24);
    goto(560);  chk("inc_25", 8'd25);
    goto(570);  bus.inc = 1'b0;

    // Second async reset mid-cycle
    goto(620);  reset = 1'b1;
    goto(621);  chk("rst2_async", 8'd77);
    goto(640);  reset = 1'b0;
    goto(660);  chk("rst2_hold", 8'd77);

    // load and inc together: load wins
    goto(700);  bus.LoadVal = 8'd10; bus.load = 1'b1; bus.inc = 1'b1;
    goto(760);  chk("prio_load", 8'd10);

    // Load 255 then one increment wraps to 0
    goto(770);  bus.LoadVal = 8'd255; bus.inc = 1'b0;
    goto(860);  chk("load_255", 8'd255);
    goto(870);  bus.load = 1'b0; bus.inc = 1'b1;
    goto(960);  chk("wrap_0", 8'd0);
    goto(970);  bus.inc = 1'b0;
    goto(1060); chk("wrap_hold", 8'd0);

    // Reset asserted together with load/inc: enables ignored
    goto(1070); bus.LoadVal = 8'd5; bus.load = 1'b1; bus.inc = 1'b1; reset = 1'b1;
    goto(1071); chk("rst_w_en", 8'd77);
    goto(1160); chk("rst_w_en_edge", 8'd77);

    // ResetVal tracked while reset held, kept after release
    goto(1170); bus.ResetVal = 8'd33;
    goto(1171); chk("rst_track", 8'd33);
    goto(1270); bus.load = 1'b0; bus.inc = 1'b0; reset = 1'b0;
    goto(1280); chk("rst_track_rel", 8'd33);
    goto(1360); chk("rst_track_hold", 8'd33);

    // inc held for three edges advances by three
    goto(1370); bus.inc = 1'b1;
    goto(1460); chk("inc_multi_1", 8'd34);
    goto(1660); chk("inc_multi_3", 8'd36);
    goto(1670); bus.inc = 1'b0;

    // inc pulse entirely between edges has no effect
    goto(1700); bus.inc = 1'b1;
    goto(1720); bus.inc = 1'b0;
    goto(1760); chk("pulse_ignored", 8'd36);

    // load held for two edges stays at LoadVal
    goto(1770); bus.LoadVal = 8'd200; bus.load = 1'b1;
    goto(1860); chk("load_multi_1", 8'd200);
    goto(1960); chk("load_multi_2", 8'd200);
    goto(1970); bus.load = 1'b0;

    // Reset mid-cycle with a pending increment
    goto(2000); bus.inc = 1'b1;
    goto(2010); reset = 1'b1;
    goto(2011); chk("rst_pending", 8'd33);
    goto(2020); bus.inc = 1'b0;
    goto(2030); reset = 1'b0;
    goto(2060); chk("rst_pend_hold", 8'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
